ps2_kbd_port_ctrl: RTL and testbench
====================================

// Module: ps2_kbd_port_ctrl
// PURPOSE
//  Keyboard input controller behind the CPU's memory-mapped keyboard port at 0xa0000000.
//  - Deserialises PS/2 frames and validates them.
//  - Queues scan codes in a small FIFO.
//  - Presents each code to the polling program as {valid, 23'b0, code}; a load pops one entry.
//  - Bit 31 = valid, so the program's "slt rX,rdata,$zero" wait loop works unchanged.
// PARAMETERS
//  FIFO_AW   3      log2 FIFO depth (8 entries)
//  FILTER    4      consecutive equal samples needed to accept a PS/2 line change
//  TIMEOUT   50000  clock cycles allowed between PS/2 falling edges inside a frame
// PORTS
//  clock      in   1   system clock; all state changes on rising edge
//  reset      in   1   synchronous, active-high reset
//  ps2_clk    in   1   raw PS/2 clock (asynchronous)
//  ps2_data   in   1   raw PS/2 data (asynchronous)
//  a          in   32  CPU data address
//  rd         in   1   CPU load strobe, high for exactly one cycle per load
//  dout       out  32  read data; combinational from registered state
//  kbd_ready  out  1   FIFO non-empty
// BEHAVIOUR
//  Reset values: dout=0, kbd_ready=0, FIFO empty, sticky flags 0, FSM=IDLE.
//  Input conditioning (applies to both ps2_clk and ps2_data):
//  - 2-FF synchroniser, then filter: a line's accepted value changes only after FILTER equal samples.
//  - Falling edge (fe) = accepted ps2_clk goes 1->0; fe is one cycle wide.
//  - ps2_data is sampled with the same accepted timing.
//  Frame FSM:
//  - IDLE:   fe & data=0 -> DATA, bitcnt=0. fe & data=1 -> stay (glitch).
//  - DATA:   each fe shifts data in LSB first. After the 8th bit -> PAR.
//  - PAR:    on fe, latch parity bit -> STOP.
//  - STOP:   on fe, check odd parity over 8 data bits + parity bit, and stop bit = 1.
//            - Both good: push byte.
//            - Parity bad: set perr.
//            - Stop bit = 0: set ferr.
//            Always return to IDLE.
//  - Watchdog: counter cleared on every fe. In any state other than IDLE, reaching TIMEOUT
//    -> IDLE, partial frame discarded, no flag set.
//  Bus decode:
//  - KBD_DATA (a==0xa0000000): dout = {~empty, 23'b0, head}; empty -> dout = 0.
//    rd & ~empty pops on that edge. rd on empty is ignored.
//  - KBD_STAT (a==0xa0000004): dout = {28'b0, ferr, perr, ovf, ~empty}.
//    rd clears ferr/perr/ovf. If a flag sets in the same cycle it is cleared, set wins.
//  - Any other address: dout = 0, no side effects.
//  FIFO:
//  - Push when full: byte dropped, ovf set, contents unchanged.
//  - Push and pop in the same cycle: both take effect, count unchanged.
//  - Push to empty with simultaneous rd: the rd sees empty (dout=0) and does not pop;
//    the byte is visible next cycle.
//  - Pointers wrap modulo 2^FIFO_AW.
//  Latency:
//  - Byte pushed on the edge where the STOP fe is seen; dout/kbd_ready reflect it next cycle.
//  - Raw pin to fe is 2 + FILTER cycles.
//  - Reset mid-frame aborts the frame and flushes the FIFO.
// STRUCTURE
//  Shared package kbd_pkg:
//  - KBD_DATA_ADDR, KBD_STAT_ADDR.
//  - Status bit indices.
//  - Frame FSM state encoding (IDLE, DATA, PAR, STOP).
//  Sub-module kbd_fifo: synchronous FIFO, 8-bit wide, 2^FIFO_AW deep.
//  - Ports: push, pop, din, dout, empty, full; first-word-fall-through.
//  Top level holds sync/filter, FSM, watchdog, decode and flags.
// TESTING
//  1. Frame 0x1C, odd parity 0 -> dout@0xa0000000 = 0x8000001C; read pops; next read 0x00000000.
//  2. Frame 0x1C with parity 1 -> no push, STAT = 0x4; read STAT, then STAT = 0x0.
//  3. Nine frames 0x01..0x09, no reads -> STAT = 0x3; reads return 0x80000001..0x80000008
//     in order, then 0.
//  4. Start bit + 4 data bits, idle TIMEOUT+10 cycles, then full 0xF0 frame
//     -> only 0x800000F0 queued, no flags.
//  5. FIFO holds 0x12; STOP fe of 0x58 in the same cycle as rd -> dout 0x80000012 that cycle,
//     then 0x80000058.
//  6. reset asserted mid-DATA with 3 bytes queued -> next cycle kbd_ready=0, STAT=0;
//     next clean frame is received correctly.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard port: bus addresses, status bits, frame FSM states.
package kbd_pkg;

  localparam logic [31:0] KBD_DATA_ADDR = 32'ha000_0000;
  localparam logic [31:0] KBD_STAT_ADDR = 32'ha000_0004;

  // Bit positions inside the KBD_STAT word
  localparam int ST_RDY  = 0;
  localparam int ST_OVF  = 1;
  localparam int ST_PERR = 2;
  localparam int ST_FERR = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } frame_state_t;

endpackage

// File: rtl/kbd_fifo.sv
// Scan-code queue: 8-bit synchronous FIFO, first-word-fall-through (dout shows the head).
module kbd_fifo #(
  parameter int AW = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  logic [7:0]    mem [2**AW];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          wr_en, rd_en;

  // Writes into a full queue and reads from an empty one are ignored here
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(2**AW));
  assign dout  = mem[rptr];

  // Pointer and occupancy update; pointers wrap naturally at 2^AW
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  // Storage is not reset; only the pointers define what is valid
  always_ff @(posedge clock) begin
    if (wr_en) mem[wptr] <= din;
  end

endmodule

// File: rtl/ps2_kbd_port_ctrl.sv
// Memory-mapped PS/2 keyboard port: line conditioning, frame FSM with watchdog,
// scan-code FIFO and CPU bus decode with sticky error flags.
module ps2_kbd_port_ctrl
  import kbd_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [31:0] a,
  input  logic        rd,
  output logic [31:0] dout,
  output logic        kbd_ready
);

  localparam int FCW = $clog2(FILTER + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);

  // Index 0 = ps2_clk, index 1 = ps2_data
  logic [1:0]          s1, s2, acc;
  logic [1:0][FCW-1:0] fcnt;
  logic                fe;

  frame_state_t state;
  logic [2:0]   bitcnt;
  logic [7:0]   sr;
  logic         par_bit;
  logic [WDW-1:0] wdog;

  logic        stop_fe, par_ok, stop_ok, push, perr_set, ferr_set, ovf_set;
  logic        is_data, is_stat, pop, stat_clr;
  logic        perr, ferr, ovf;
  logic [7:0]  head;
  logic        empty, full;

  // Two-flop synchroniser plus a run-length filter; fe pulses for one cycle when
  // the accepted clock line falls, so the accepted data line is already settled
  always_ff @(posedge clock) begin
    if (reset) begin
      s1   <= '1;
      s2   <= '1;
      acc  <= '1;
      fcnt <= '0;
      fe   <= 1'b0;
    end else begin
      s1 <= {ps2_data, ps2_clk};
      s2 <= s1;
      fe <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == acc[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCW'(FILTER - 1)) begin
          acc[i]  <= s2[i];
          fcnt[i] <= '0;
          if (i == 0 && !s2[i]) fe <= 1'b1;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  // Frame completion: push is taken on the same edge the STOP falling edge is seen
  always_comb begin
    stop_fe  = fe && (state == S_STOP);
    par_ok   = ^{sr, par_bit};
    stop_ok  = acc[1];
    push     = stop_fe & par_ok & stop_ok;
    perr_set = stop_fe & ~par_ok;
    ferr_set = stop_fe & ~stop_ok;
    ovf_set  = push & full;
  end

  // Frame FSM with watchdog; a stalled partial frame is silently discarded
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      bitcnt  <= '0;
      sr      <= '0;
      par_bit <= 1'b0;
      wdog    <= '0;
    end else begin
      if (state == S_IDLE || fe) wdog <= '0;
      else                       wdog <= wdog + 1'b1;

      if (fe) begin
        case (state)
          S_IDLE: if (!acc[1]) begin
            state  <= S_DATA;
            bitcnt <= '0;
          end
          S_DATA: begin
            sr     <= {acc[1], sr[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= S_PAR;
          end
          S_PAR:  begin
            par_bit <= acc[1];
            state   <= S_STOP;
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE && wdog == WDW'(TIMEOUT - 1)) begin
        state <= S_IDLE;
      end
    end
  end

  // Bus decode; a data read on an empty queue has no effect
  always_comb begin
    is_data  = (a == KBD_DATA_ADDR);
    is_stat  = (a == KBD_STAT_ADDR);
    pop      = rd & is_data & ~empty;
    stat_clr = rd & is_stat;
  end

  // Sticky error flags; a set in the clearing cycle survives
  always_ff @(posedge clock) begin
    if (reset) begin
      perr <= 1'b0;
      ferr <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      perr <= perr_set | (perr & ~stat_clr);
      ferr <= ferr_set | (ferr & ~stat_clr);
      ovf  <= ovf_set  | (ovf  & ~stat_clr);
    end
  end

  kbd_fifo #(.AW(FIFO_AW)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (sr),
    .dout  (head),
    .empty (empty),
    .full  (full)
  );

  // Read mux; bit 31 doubles as the valid flag for the polling loop
  always_comb begin
    dout = '0;
    if (is_data && !empty) begin
      dout = {1'b1, 23'b0, head};
    end else if (is_stat) begin
      dout[ST_RDY]  = ~empty;
      dout[ST_OVF]  = ovf;
      dout[ST_PERR] = perr;
      dout[ST_FERR] = ferr;
    end
  end

  assign kbd_ready = ~empty;

endmodule

// File: tb/tb_ps2_kbd_port_ctrl.sv
// Directed bench for the PS/2 keyboard port controller.
module tb_ps2_kbd_port_ctrl;

  localparam int TIMEOUT = 50000;
  localparam logic [31:0] DADDR = 32'ha000_0000;
  localparam logic [31:0] SADDR = 32'ha000_0004;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] a = '0;
  logic        rd = 1'b0;
  logic [31:0] dout;
  logic        kbd_ready;

  int n_cmp = 0;
  int n_fail = 0;

  ps2_kbd_port_ctrl #(.FIFO_AW(3), .FILTER(4), .TIMEOUT(TIMEOUT)) dut (
    .clock     (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .a         (a),
    .rd        (rd),
    .dout      (dout),
    .kbd_ready (kbd_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL global_timeout: simulation did not finish, got running, need finished");
    $fatal(1, "bench timeout");
  end

  // Advance n rising edges, then step 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(10);
    ps2_clk = 1'b0;
    tick(10);
    ps2_clk = 1'b1;
  endtask

  // Start, 8 data LSB first, odd parity (optionally inverted), stop
  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stopb);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ flip);
    send_bit(stopb);
    ps2_data = 1'b1;
    tick(20);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] v);
    a  = addr;
    rd = 1'b1;
    #1 v = dout;
    tick(1);
    rd = 1'b0;
    a  = '0;
  endtask

  task automatic peek(input logic [31:0] addr, output logic [31:0] v);
    a = addr;
    #1 v = dout;
    a = '0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    peek(DADDR, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h need %h", v, 32'h0); end
    peek(SADDR, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_stat: got %h need %h", v, 32'h0); end
    n_cmp++; if (kbd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b need 0", kbd_ready); end
  endtask

  task automatic test_basic;
    logic [31:0] v;
    send_frame(8'h1C, 1'b0, 1'b1);
    n_cmp++; if (kbd_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b need 1", kbd_ready); end
    bus_read(32'ha000_0008, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL other_addr: got %h need %h", v, 32'h0); end
    bus_read(DADDR, v);
    n_cmp++; if (v !== 32'h8000001C) begin n_fail++; $display("FAIL basic_data: got %h need %h", v, 32'h8000001C); end
    bus_read(DADDR, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL basic_empty: got %h need %h", v, 32'h0); end
  endtask

  task automatic test_parity_err;
    logic [31:0] v;
    send_frame(8'h1C, 1'b1, 1'b1);
    bus_read(SADDR, v);
    n_cmp++; if (v !== 32'h4) begin n_fail++; $display("FAIL perr_stat: got %h need %h", v, 32'h4); end
    peek(SADDR, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL perr_clear: got %h need %h", v, 32'h0); end
  endtask

  task automatic test_framing_err;
    logic [31:0] v;
    send_frame(8'h33, 1'b0, 1'b0);
    bus_read(SADDR, v);
    n_cmp++; if (v !== 32'h8) begin n_fail++; $display("FAIL ferr_stat: got %h need %h", v, 32'h8); end
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1);
    bus_read(SADDR, v);
    n_cmp++; if (v !== 32'h3) begin n_fail++; $display("FAIL ovf_stat: got %h need %h", v, 32'h3); end
    peek(SADDR, v);
    n_cmp++; if (v !== 32'h1) begin n_fail++; $display("FAIL ovf_clear: got %h need %h", v, 32'h1); end
    for (int i = 1; i <= 8; i++) begin
      bus_read(DADDR, v);
      n_cmp++;
      if (v !== (32'h80000000 | 32'(i))) begin
        n_fail++; $display("FAIL ovf_order%0d: got %h need %h", i, v, 32'h80000000 | 32'(i));
      end
    end
    bus_read(DADDR, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL ovf_empty: got %h need %h", v, 32'h0); end
  endtask

  task automatic test_timeout;
    logic [31:0] v;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    ps2_data = 1'b1;
    tick(TIMEOUT + 10);
    send_frame(8'hF0, 1'b0, 1'b1);
    peek(SADDR, v);
    n_cmp++; if (v !== 32'h1) begin n_fail++; $display("FAIL tmo_stat: got %h need %h", v, 32'h1); end
    bus_read(DADDR, v);
    n_cmp++; if (v !== 32'h800000F0) begin n_fail++; $display("FAIL tmo_data: got %h need %h", v, 32'h800000F0); end
    bus_read(DADDR, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL tmo_empty: got %h need %h", v, 32'h0); end
  endtask

  // Line falls just after edge N; the registered fe is high between N+6 and N+7
  task automatic test_back_to_back;
    logic [31:0] v;
    logic [7:0]  d;
    send_frame(8'h12, 1'b0, 1'b1);
    d = 8'h58;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(~^d);
    ps2_data = 1'b1;
    tick(10);
    ps2_clk = 1'b0;
    tick(6);
    a  = DADDR;
    rd = 1'b1;
    #1 v = dout;
    n_cmp++; if (v !== 32'h80000012) begin n_fail++; $display("FAIL b2b_head: got %h need %h", v, 32'h80000012); end
    tick(1);
    rd = 1'b0;
    #1 v = dout;
    n_cmp++; if (v !== 32'h80000058) begin n_fail++; $display("FAIL b2b_next: got %h need %h", v, 32'h80000058); end
    a = '0;
    tick(3);
    ps2_clk = 1'b1;
    tick(20);
    bus_read(DADDR, v);
    n_cmp++; if (v !== 32'h80000058) begin n_fail++; $display("FAIL b2b_pop: got %h need %h", v, 32'h80000058); end
    bus_read(DADDR, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL b2b_empty: got %h need %h", v, 32'h0); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] v;
    send_frame(8'h21, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    send_frame(8'h23, 1'b0, 1'b1);
    n_cmp++; if (kbd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ready: got %b need 1", kbd_ready); end
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_data = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    n_cmp++; if (kbd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b need 0", kbd_ready); end
    peek(SADDR, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_stat: got %h need %h", v, 32'h0); end
    tick(30);
    send_frame(8'h66, 1'b0, 1'b1);
    bus_read(DADDR, v);
    n_cmp++; if (v !== 32'h80000066) begin n_fail++; $display("FAIL rst_next: got %h need %h", v, 32'h80000066); end
    bus_read(DADDR, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_empty: got %h need %h", v, 32'h0); end
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    tick(2);
    test_reset();
    test_basic();
    test_parity_err();
    test_framing_err();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
